// File: rtl/tcdm_resv_table.sv
// tcdm_resv_table: multi-entry LR/SC reservation table in front of one TCDM bank
module tcdm_resv_table #(
  parameter int NumResv = 4,
  parameter int IniIdWidth = 4,
  parameter int AddrWidth = 8,
  parameter int DataWidth = 32,
  parameter int TimeoutCycles = 0,
  localparam int BeWidth = DataWidth / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [AddrWidth-1:0]  req_addr_i,
  input  logic                  req_wen_i,
  input  logic [3:0]            req_amo_i,
  input  logic [IniIdWidth-1:0] req_ini_i,
  input  logic [DataWidth-1:0]  req_data_i,
  input  logic [BeWidth-1:0]    req_be_i,
  output logic                  bank_valid_o,
  input  logic                  bank_ready_i,
  output logic                  bank_wen_o,
  output logic [AddrWidth-1:0]  bank_addr_o,
  output logic [DataWidth-1:0]  bank_data_o,
  output logic [BeWidth-1:0]    bank_be_o,
  input  logic [DataWidth-1:0]  bank_rdata_i,
  output logic                  resp_valid_o,
  output logic [IniIdWidth-1:0] resp_ini_o,
  output logic [DataWidth-1:0]  resp_data_o
);
  function automatic int idx_width(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int IW = idx_width(NumResv);
  localparam int AGW = TimeoutCycles > 2 ? $clog2(TimeoutCycles) : 1;
  localparam logic [AGW-1:0] AGE_MAX = AGW'(TimeoutCycles > 0 ? TimeoutCycles - 1 : 0);
  localparam logic [3:0] AMO_LR = 4'hA;
  localparam logic [3:0] AMO_SC = 4'hB;
  logic [NumResv-1:0]    vld_q, keep;
  logic [IniIdWidth-1:0] ini_q [NumResv];
  logic [AddrWidth-1:0]  addr_q [NumResv];
  logic [AGW-1:0]        age_q [NumResv];
  logic [IW-1:0]         rr_q, rr_d, own_idx, free_idx, alloc_idx;
  logic                  hs, is_lr, is_sc, sc_ok, wr_clr, own_hit, free_hit;
  logic                  resp_valid_q, resp_sc_q, resp_fail_q;
  logic [IniIdWidth-1:0] resp_ini_q;
  assign hs = req_valid_i & bank_ready_i;
  assign is_lr = req_amo_i == AMO_LR;
  assign is_sc = req_amo_i == AMO_SC;
  assign req_ready_o = bank_ready_i;
  assign bank_valid_o = req_valid_i;
  assign bank_addr_o = req_addr_i;
  assign bank_data_o = req_data_i;
  assign bank_wen_o = is_sc | (~is_lr & req_wen_i);
  assign bank_be_o = (is_sc & ~sc_ok) ? '0 : req_be_i;
  // Clears (expiry, write snoop, SC consume) are folded into keep before LR picks a slot.
  always_comb begin
    sc_ok = 1'b0;
    for (int i = 0; i < NumResv; i++)
      sc_ok |= vld_q[i] && ini_q[i] == req_ini_i && addr_q[i] == req_addr_i;
    wr_clr = hs && (is_sc ? sc_ok : (!is_lr && (req_wen_i || req_amo_i != 4'h0)));
    keep = '0;
    own_hit = 1'b0;
    own_idx = '0;
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = NumResv - 1; i >= 0; i--) begin
      keep[i] = vld_q[i] && !(TimeoutCycles > 0 && age_q[i] == AGE_MAX)
                && !(wr_clr && addr_q[i] == req_addr_i)
                && !(hs && is_sc && ini_q[i] == req_ini_i);
      if (keep[i] && ini_q[i] == req_ini_i) begin
        own_hit = 1'b1;
        own_idx = IW'(i);
      end
      if (!keep[i]) begin
        free_hit = 1'b1;
        free_idx = IW'(i);
      end
    end
    alloc_idx = own_hit ? own_idx : free_hit ? free_idx : rr_q;
    rr_d = (hs && is_lr && !own_hit && !free_hit)
           ? (rr_q == IW'(NumResv - 1) ? '0 : rr_q + IW'(1)) : rr_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      rr_q <= '0;
      resp_valid_q <= 1'b0;
      resp_ini_q <= '0;
      resp_sc_q <= 1'b0;
      resp_fail_q <= 1'b0;
      for (int i = 0; i < NumResv; i++) begin
        ini_q[i] <= '0;
        addr_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      resp_valid_q <= hs;
      if (hs) begin
        resp_ini_q <= req_ini_i;
        resp_sc_q <= is_sc;
        resp_fail_q <= is_sc && !sc_ok;
      end
      for (int i = 0; i < NumResv; i++) begin
        if (hs && is_lr && alloc_idx == IW'(i)) begin
          vld_q[i] <= 1'b1;
          ini_q[i] <= req_ini_i;
          addr_q[i] <= req_addr_i;
          age_q[i] <= '0;
        end else begin
          vld_q[i] <= keep[i];
          age_q[i] <= !keep[i] ? '0 : age_q[i] == AGE_MAX ? age_q[i] : age_q[i] + AGW'(1);
        end
      end
    end
  end
  assign resp_valid_o = resp_valid_q;
  assign resp_ini_o = resp_ini_q;
  assign resp_data_o = resp_valid_q ? (resp_sc_q ? DataWidth'(resp_fail_q) : bank_rdata_i) : '0;
endmodule
